// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the control FSM state encoding, the opcodes the controller
// recognises, the datapath select encodings and the ALU control codes
// produced by alu_decoder.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_LOGIEX = 4'd9,
    S_IMMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGI  = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder, placed beside multicycle_ctrl.
// Ports:
//   alu_op     in  2  operation class from the control FSM
//   funct      in  6  ir[5:0], used for R-type
//   opcode_lsb in  1  opcode[0], selects and/or for immediate logic
//   alu_ctl    out 4  ALU control code
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic       opcode_lsb,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALUCTL_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALUCTL_ADD;
      ALUOP_SUB: alu_ctl = ALUCTL_SUB;
      ALUOP_LOGI: alu_ctl = opcode_lsb ? ALUCTL_OR : ALUCTL_AND;
      default: begin
        case (funct)
          FN_ADD:  alu_ctl = ALUCTL_ADD;
          FN_SUB:  alu_ctl = ALUCTL_SUB;
          FN_AND:  alu_ctl = ALUCTL_AND;
          FN_OR:   alu_ctl = ALUCTL_OR;
          FN_SLT:  alu_ctl = ALUCTL_SLT;
          default: alu_ctl = ALUCTL_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. Sequences fetch, decode,
// execute, memory and write-back, driving every datapath select and
// write enable, and counts retired instructions.
// Ports:
//   clk, reset_n (async, active low)
//   opcode, zero, mem_ready                         inputs
//   mem_req, mem_write, iord, ir_write, pc_write    memory / PC / IR control
//   pc_src, alu_src_a, alu_src_b, alu_op, ext_op    datapath selects
//   reg_dst, mem_to_reg, reg_write                  register file control
//   illegal                                         unknown-opcode pulse
//   retired                                         completed instruction count
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            ext_op,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            retire;

  // The handshake is masked during reset so that no enable can fire while
  // the block is being held in FETCH.
  logic rdy;
  assign rdy = mem_ready & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    ext_op     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (sext(imm) << 2) is computed here speculatively.
        alu_src_b = SRCB_IMMSH2;
        ext_op    = 1'b1;
        if (opcode == OPW'(OP_RTYPE))                              state_d = S_EXEC;
        else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))   state_d = S_MEMADR;
        else if (opcode == OPW'(OP_BEQ))                           state_d = S_BRANCH;
        else if (opcode == OPW'(OP_ADDI))                          state_d = S_ADDIEX;
        else if (opcode == OPW'(OP_ANDI) || opcode == OPW'(OP_ORI)) state_d = S_LOGIEX;
        else if (opcode == OPW'(OP_J))                             state_d = S_JUMP;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        state_d   = (opcode == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        state_d   = S_IMMWB;
      end
      S_LOGIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_LOGI;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + CNTW'(1) : retired_q;
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [5:0]  funct;
  logic        mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, ext_op, reg_dst, mem_to_reg, reg_write, illegal;
  logic [31:0] retired;
  logic [3:0]  alu_ctl;

  int n_cmp = 0;
  int n_err = 0;
  int wb_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPW(6), .CNTW(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .retired(retired)
  );

  alu_decoder u_alu_dec (
    .alu_op(alu_op), .funct(funct), .opcode_lsb(opcode[0]), .alu_ctl(alu_ctl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check that the FSM sits in FETCH, then move on to DECODE with ready memory.
  task automatic fetch(input logic [5:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(dut.state_q), 32'(S_FETCH));
    chk("fetch_irw", 32'(ir_write), 32'd1);
    tick();
    chk("decode_state", 32'(dut.state_q), 32'(S_DECODE));
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1; funct = 6'h22;
    #3;
    chk("rst_pcw", 32'(pc_write), 32'd0);
    chk("rst_irw", 32'(ir_write), 32'd0);
    chk("rst_ret", retired, 32'd0);
    chk("rst_req", 32'(mem_req), 32'd1);
    chk("rst_srcb", 32'(alu_src_b), 32'(SRCB_FOUR));
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold", 32'(dut.state_q), 32'(S_FETCH));
    reset_n = 1'b1;

    // R-type: FETCH DECODE EXEC ALUWB
    fetch(OP_RTYPE);
    chk("dec_srcb", 32'(alu_src_b), 32'(SRCB_IMMSH2));
    chk("dec_ext", 32'(ext_op), 32'd1);
    tick();
    chk("exec_state", 32'(dut.state_q), 32'(S_EXEC));
    chk("exec_aluop", 32'(alu_op), 32'(ALUOP_FUNCT));
    chk("exec_srca", 32'(alu_src_a), 32'd1);
    chk("exec_aluctl_sub", 32'(alu_ctl), 32'(ALUCTL_SUB));
    tick();
    chk("aluwb_state", 32'(dut.state_q), 32'(S_ALUWB));
    chk("aluwb_rw", 32'(reg_write), 32'd1);
    chk("aluwb_dst", 32'(reg_dst), 32'd1);
    tick();
    chk("rtype_ret", retired, 32'd1);
    $display("instr rtype done retired=%0d", retired);

    // lw with 2 wait cycles in FETCH and in MEMRD: 9 cycles total
    opcode = OP_LW;
    wb_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      mem_ready = (c == 0 || c == 1 || c == 5 || c == 6) ? 1'b0 : 1'b1;
      #1;
      if (c == 0) chk("lw_wait_pcw", 32'(pc_write), 32'd0);
      if (c == 4) chk("lw_memadr_ext", 32'(ext_op), 32'd1);
      if (c == 5) begin
        chk("lw_memrd_state", 32'(dut.state_q), 32'(S_MEMRD));
        chk("lw_memrd_iord", 32'(iord), 32'd1);
      end
      if (reg_write && mem_to_reg) wb_cnt++;
      tick();
    end
    chk("lw_end_state", 32'(dut.state_q), 32'(S_FETCH));
    chk("lw_wb_once", 32'(wb_cnt), 32'd1);
    chk("lw_ret", retired, 32'd2);
    $display("instr lw done retired=%0d", retired);

    // addi
    fetch(OP_ADDI);
    tick();
    chk("addi_state", 32'(dut.state_q), 32'(S_ADDIEX));
    chk("addi_ext", 32'(ext_op), 32'd1);
    chk("addi_aluop", 32'(alu_op), 32'(ALUOP_ADD));
    chk("addi_srcb", 32'(alu_src_b), 32'(SRCB_IMM));
    tick();
    chk("immwb_rw", 32'(reg_write), 32'd1);
    chk("immwb_dst", 32'(reg_dst), 32'd0);
    tick();
    chk("addi_ret", retired, 32'd3);
    $display("instr addi done retired=%0d", retired);

    // andi
    fetch(OP_ANDI);
    tick();
    chk("andi_state", 32'(dut.state_q), 32'(S_LOGIEX));
    chk("andi_ext", 32'(ext_op), 32'd0);
    chk("andi_aluop", 32'(alu_op), 32'(ALUOP_LOGI));
    chk("andi_aluctl", 32'(alu_ctl), 32'(ALUCTL_AND));
    tick(); tick();
    chk("andi_ret", retired, 32'd4);
    $display("instr andi done retired=%0d", retired);

    // ori
    fetch(OP_ORI);
    tick();
    chk("ori_ext", 32'(ext_op), 32'd0);
    chk("ori_aluop", 32'(alu_op), 32'(ALUOP_LOGI));
    chk("ori_aluctl", 32'(alu_ctl), 32'(ALUCTL_OR));
    tick(); tick();
    chk("ori_ret", retired, 32'd5);
    $display("instr ori done retired=%0d", retired);

    // beq taken
    zero = 1'b1;
    fetch(OP_BEQ);
    tick();
    chk("beq1_state", 32'(dut.state_q), 32'(S_BRANCH));
    chk("beq1_pcw", 32'(pc_write), 32'd1);
    chk("beq1_pcsrc", 32'(pc_src), 32'(PCSRC_ALUOUT));
    chk("beq1_aluop", 32'(alu_op), 32'(ALUOP_SUB));
    tick();
    $display("instr beq(taken) done retired=%0d", retired);
    // beq not taken
    zero = 1'b0;
    fetch(OP_BEQ);
    tick();
    chk("beq0_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("beq_ret", retired, 32'd7);
    $display("instr beq(not taken) done retired=%0d", retired);

    // illegal opcode
    fetch(6'h3F);
    chk("ill_pulse", 32'(illegal), 32'd1);
    tick();
    chk("ill_next", 32'(dut.state_q), 32'(S_FETCH));
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("ill_ret", retired, 32'd7);
    $display("instr illegal done retired=%0d", retired);

    // jump
    fetch(OP_J);
    tick();
    chk("j_pcw", 32'(pc_write), 32'd1);
    chk("j_pcsrc", 32'(pc_src), 32'(PCSRC_JUMP));
    tick();
    chk("j_ret", retired, 32'd8);
    $display("instr j done retired=%0d", retired);

    // sw interrupted by reset while waiting in MEMWR
    fetch(OP_SW);
    tick();
    chk("sw_memadr", 32'(dut.state_q), 32'(S_MEMADR));
    mem_ready = 1'b0;
    tick();
    chk("sw_memwr_state", 32'(dut.state_q), 32'(S_MEMWR));
    chk("sw_memwr_wr", 32'(mem_write), 32'd1);
    tick();
    chk("sw_memwr_hold", 32'(dut.state_q), 32'(S_MEMWR));
    #2;
    reset_n = 1'b0;
    #1;
    chk("sw_rst_state", 32'(dut.state_q), 32'(S_FETCH));
    chk("sw_rst_wr", 32'(mem_write), 32'd0);
    chk("sw_rst_ret", retired, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("sw_rst_irw", 32'(ir_write), 32'd0);
    tick();
    reset_n = 1'b1;
    $display("instr sw aborted by reset retired=%0d", retired);

    // full sw, zero-wait: 4 cycles
    fetch(OP_SW);
    tick(); tick();
    chk("sw2_memwr", 32'(mem_write), 32'd1);
    tick();
    chk("sw2_state", 32'(dut.state_q), 32'(S_FETCH));
    chk("sw2_ret", retired, 32'd1);
    $display("instr sw done retired=%0d", retired);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multi-cycle variant of the CPU datapath. Sequences instruction fetch, decode, execute, memory access and write-back over multiple clocks. Drives every datapath select and write enable, including `ext_op` for the immediate extender (sign vs. zero extension). Stalls on a simple memory ready handshake.

## Interface
Parameters:
- `OPW`, 6: opcode width.
- `CNTW`, 32: retired-instruction counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  `ir[31:26]`, valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BRANCH.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request active.
- `mem_write`  out  1  request is a store.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  load PC.
- `pc_src`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = extended immediate, 11 = extended immediate << 2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct decode, 11 = immediate logic (ALU decoder uses `opcode[0]`: 0 = and, 1 = or).
- `ext_op`  out  1  1 = sign-extend imm16, 0 = zero-extend.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.
- `retired`  out  CNTW  count of completed instructions.

## Operation
- Moore FSM. Outputs decode from the state register only, except the gated enables noted below. Any signal not listed for a state is 0.
- FETCH: `mem_req` = 1, `iord` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_src` = 00. `ir_write` and `pc_write` equal `mem_ready`. Stays in FETCH while `mem_ready` = 0; goes to DECODE when it is 1.
- DECODE: `alu_src_a` = 0, `alu_src_b` = 11, `alu_op` = 00, `ext_op` = 1 (precomputes the branch target). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x08 → ADDIEX
  - 0x0C or 0x0D → LOGIEX
  - 0x02 → JUMP
  - anything else → FETCH, with `illegal` = 1 for this cycle.
- MEMADR: `alu_src_a` = 1, `alu_src_b` = 10, `ext_op` = 1, `alu_op` = 00. Goes to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: `mem_req` = 1, `iord` = 1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 1. Goes to FETCH.
- MEMWR: `mem_req` = 1, `mem_write` = 1, `iord` = 1. Holds until `mem_ready`, then goes to FETCH.
- EXEC: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10. Goes to ALUWB.
- ALUWB: `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0. Goes to FETCH.
- ADDIEX: `alu_src_a` = 1, `alu_src_b` = 10, `ext_op` = 1, `alu_op` = 00. Goes to IMMWB.
- LOGIEX: same as ADDIEX but `ext_op` = 0 and `alu_op` = 11. Goes to IMMWB.
- IMMWB: `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 0. Goes to FETCH.
- BRANCH: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_src` = 01, `pc_write` = `zero`. Goes to FETCH.
- JUMP: `pc_src` = 10, `pc_write` = 1. Goes to FETCH.
- `retired` increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH or JUMP. It never increments on the illegal DECODE → FETCH path. It wraps modulo 2^CNTW.

## Timing
- Reset (asynchronous assert): state = FETCH, `retired` = 0. Outputs immediately take FETCH values: `mem_req` = 1, `alu_src_b` = 01; all enables 0 because `mem_ready` is ignored while `reset_n` = 0.
- Reset deassertion: the first fetch may complete on the first rising edge after release.
- Latency with `mem_ready` always 1: R-type 4, lw 5, sw 4, addi/andi/ori 4, beq 3, j 3 clocks. Each memory wait cycle adds 1.
- `mem_ready` is ignored in every state that does not assert `mem_req`.
- Reset asserted mid-instruction: the instruction is abandoned, no partial `reg_write` or `pc_write` occurs after assertion, and the counter is not incremented.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum (13 states, 4-bit encoding);
  - opcode localparams (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_ANDI`, `OP_ORI`, `OP_J`);
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `alu_decoder` (combinational): maps `alu_op` plus funct or `opcode[0]` to the ALU control code. It is instantiated beside this block, not inside it.
- The FSM next-state logic, output decode and counter stay in this one module.

## Test plan
- Reset: hold `reset_n` = 0 with `mem_ready` = 1 → `pc_write` = 0, `ir_write` = 0, `retired` = 0. Release, then opcode 0x00 with zero-wait memory → states FETCH, DECODE, EXEC, ALUWB, then `retired` = 1.
- lw (0x23) with `mem_ready` low for 2 cycles in both FETCH and MEMRD → 9 cycles total; `reg_write` = 1 with `mem_to_reg` = 1 exactly once; `ext_op` = 1 in MEMADR.
- andi (0x0C) and ori (0x0D) → `ext_op` = 0 and `alu_op` = 11 in LOGIEX. addi (0x08) → `ext_op` = 1 and `alu_op` = 00.
- beq (0x04) with `zero` = 1, then again with `zero` = 0 → `pc_write` = 1 and then 0 in BRANCH; both retire (`retired` += 2).
- Opcode 0x3F → `illegal` pulses for 1 cycle in DECODE, next state is FETCH, `retired` unchanged.
- Assert `reset_n` during MEMWR with `mem_ready` = 0 → state becomes FETCH asynchronously, `mem_write` drops to 0 the same cycle, `retired` = 0.
